// File: rtl/axil_wb_pkg.sv
// Shared definitions for the AXI-lite to Wishbone read and write bridges.
package axil_wb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of byte-address bits dropped to form a word address.
  function automatic int unsigned AXI_LSBS(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axilwr_bfifo.sv
// One-bit-wide response FIFO for the write bridge; a set bit marks an SLVERR.
module axilwr_bfifo #(
  parameter int unsigned LgDepth = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             data_i,
  input  logic             pop_i,
  output logic             data_o,
  output logic [LgDepth:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Depth = 1 << LgDepth;

  logic [Depth-1:0]   mem_q, mem_d;
  logic [LgDepth-1:0] wr_ptr_q, wr_ptr_d;
  logic [LgDepth-1:0] rd_ptr_q, rd_ptr_d;
  logic [LgDepth:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (LgDepth + 1)'(Depth));
  assign empty_o = (count_q == '0);

  // Next-state: a push into a full FIFO is allowed when a pop frees the slot.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + LgDepth'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + LgDepth'(1);
    end
    count_d = count_q + (LgDepth + 1)'(do_push) - (LgDepth + 1)'(do_pop);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries below count_q are ever read out.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axilwr2wbsp.sv
// AXI-lite write channel (AW/W/B) to pipelined Wishbone write bridge.
module axilwr2wbsp
  import axil_wb_pkg::*;
#(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 28,
  parameter int unsigned LGFIFO           = 3,
  localparam int unsigned DW = C_AXI_DATA_WIDTH,
  localparam int unsigned AW = C_AXI_ADDR_WIDTH - AXI_LSBS(C_AXI_DATA_WIDTH)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_axi_awvalid,
  output logic            o_axi_awready,
  input  logic [AW-1:0]   i_axi_awaddr,
  input  logic [2:0]      i_axi_awprot,
  input  logic            i_axi_wvalid,
  output logic            o_axi_wready,
  input  logic [DW-1:0]   i_axi_wdata,
  input  logic [DW/8-1:0] i_axi_wstrb,
  output logic            o_axi_bvalid,
  input  logic            i_axi_bready,
  output logic [1:0]      o_axi_bresp,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err
);

  localparam int unsigned FLEN = 1 << LGFIFO;
  localparam int unsigned CW   = LGFIFO + 2;

  typedef logic [LGFIFO:0] cnt_t;

  logic            aw_held_q, aw_held_d;
  logic [AW-1:0]   aw_addr_q, aw_addr_d;
  logic            w_held_q, w_held_d;
  logic [DW-1:0]   w_data_q, w_data_d;
  logic [DW/8-1:0] w_strb_q, w_strb_d;
  logic            stb_q, stb_d;
  logic            cyc_q, cyc_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW/8-1:0] sel_q, sel_d;
  cnt_t            inflight_q, inflight_d;
  cnt_t            flush_q, flush_d;

  logic            aw_hs, w_hs, accepted, ack_ev, err_ev, flushing, credit_ok, issue;
  logic [CW-1:0]   credit_need;
  cnt_t            owed;
  logic            push, push_err, pop;
  logic            fifo_head, fifo_full, fifo_empty;
  cnt_t            fifo_count;
  logic            unused_sig;

  assign unused_sig = ^{i_axi_awprot, fifo_full};

  assign o_axi_awready = !aw_held_q;
  assign o_axi_wready  = !w_held_q;
  assign o_axi_bvalid  = !fifo_empty;
  assign o_axi_bresp   = (!fifo_empty && fifo_head) ? RESP_SLVERR : RESP_OKAY;
  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = stb_q;
  assign o_wb_we       = 1'b1;
  assign o_wb_addr     = addr_q;
  assign o_wb_data     = data_q;
  assign o_wb_sel      = sel_q;
  assign pop           = o_axi_bvalid && i_axi_bready;

  // Event decode and issue qualification.
  always_comb begin
    aw_hs    = i_axi_awvalid && !aw_held_q;
    w_hs     = i_axi_wvalid && !w_held_q;
    accepted = stb_q && !i_wb_stall;
    err_ev   = cyc_q && i_wb_err;
    ack_ev   = cyc_q && i_wb_ack && !i_wb_err;
    flushing = (flush_q != '0);
    // A presented-but-unaccepted strobe already owns a response slot.
    credit_need = CW'(inflight_q) + CW'(stb_q) + CW'(fifo_count) + CW'(1);
    credit_ok   = (credit_need <= CW'(FLEN));
    issue = (aw_held_q || aw_hs) && (w_held_q || w_hs) && (!stb_q || !i_wb_stall) &&
            !flushing && !err_ev && credit_ok;
    owed  = inflight_q + cnt_t'(stb_q);
  end

  // Next-state for holding registers, bus request and response bookkeeping.
  always_comb begin
    aw_held_d  = aw_held_q;
    aw_addr_d  = aw_addr_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sel_d      = sel_q;
    stb_d      = stb_q;
    cyc_d      = cyc_q;
    inflight_d = inflight_q;
    flush_d    = flush_q;

    if (aw_hs) aw_addr_d = i_axi_awaddr;
    if (w_hs) begin
      w_data_d = i_axi_wdata;
      w_strb_d = i_axi_wstrb;
    end
    if (issue) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      addr_d    = aw_held_q ? aw_addr_q : i_axi_awaddr;
      data_d    = w_held_q ? w_data_q : i_axi_wdata;
      sel_d     = w_held_q ? w_strb_q : i_axi_wstrb;
    end else begin
      if (aw_hs) aw_held_d = 1'b1;
      if (w_hs) w_held_d = 1'b1;
    end

    if (err_ev) begin
      stb_d      = 1'b0;
      cyc_d      = 1'b0;
      inflight_d = '0;
      // The erroring write answers now; everything else still owed is flushed.
      flush_d    = (owed == '0) ? '0 : owed - cnt_t'(1);
    end else begin
      if (issue) stb_d = 1'b1;
      else if (accepted) stb_d = 1'b0;
      inflight_d = inflight_q + cnt_t'(accepted) - cnt_t'(ack_ev);
      cyc_d      = issue || (cyc_q && (stb_q || inflight_q != '0));
      if (flushing) flush_d = flush_q - cnt_t'(1);
    end

    push     = ack_ev || flushing || (err_ev && owed != '0);
    push_err = !ack_ev;
  end

  // Control state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      stb_q      <= 1'b0;
      cyc_q      <= 1'b0;
      inflight_q <= '0;
      flush_q    <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      stb_q      <= stb_d;
      cyc_q      <= cyc_d;
      inflight_q <= inflight_d;
      flush_q    <= flush_d;
    end
  end

  // Datapath registers; only meaningful while their valid/strobe flag is set.
  always_ff @(posedge i_clk) begin
    aw_addr_q <= aw_addr_d;
    w_data_q  <= w_data_d;
    w_strb_q  <= w_strb_d;
    addr_q    <= addr_d;
    data_q    <= data_d;
    sel_q     <= sel_d;
  end

  axilwr_bfifo #(
    .LgDepth (LGFIFO)
  ) u_bfifo (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .push_i  (push),
    .data_i  (push_err),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_axilwr2wbsp.sv
// Bench for axilwr2wbsp: AXI writes are paired in order and checked on the Wishbone side;
// a Wishbone slave model derives the expected B response stream.
module tb_axilwr2wbsp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 26;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_axi_awvalid, o_axi_awready;
  logic [AW-1:0] i_axi_awaddr;
  logic [2:0]    i_axi_awprot;
  logic          i_axi_wvalid, o_axi_wready;
  logic [DW-1:0] i_axi_wdata;
  logic [SW-1:0] i_axi_wstrb;
  logic          o_axi_bvalid, i_axi_bready;
  logic [1:0]    o_axi_bresp;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic [SW-1:0] o_wb_sel;
  logic          i_wb_stall, i_wb_ack, i_wb_err;

  always #5 clk = ~clk;

  axilwr2wbsp dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_axi_awvalid (i_axi_awvalid),
    .o_axi_awready (o_axi_awready),
    .i_axi_awaddr  (i_axi_awaddr),
    .i_axi_awprot  (i_axi_awprot),
    .i_axi_wvalid  (i_axi_wvalid),
    .o_axi_wready  (o_axi_wready),
    .i_axi_wdata   (i_axi_wdata),
    .i_axi_wstrb   (i_axi_wstrb),
    .o_axi_bvalid  (o_axi_bvalid),
    .i_axi_bready  (i_axi_bready),
    .o_axi_bresp   (o_axi_bresp),
    .o_wb_cyc      (o_wb_cyc),
    .o_wb_stb      (o_wb_stb),
    .o_wb_we       (o_wb_we),
    .o_wb_addr     (o_wb_addr),
    .o_wb_data     (o_wb_data),
    .o_wb_sel      (o_wb_sel),
    .i_wb_stall    (i_wb_stall),
    .i_wb_ack      (i_wb_ack),
    .i_wb_err      (i_wb_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [AW-1:0]    aw_q[$];
  logic [DW+SW-1:0] w_q[$];
  logic [1:0]       exp_b[$];
  int               ready_at[$];
  int cyc_n = 0;
  int ack_min = 1, ack_max = 1, stall_pct = 0, bready_pct = 100, err_pct = 0;
  int err_at_resp = 0, resp_idx = 0, wb_acc = 0;
  logic chk_after_err = 1'b0;
  logic [AW-1:0]    m_a;
  logic [DW+SW-1:0] m_w;
  int               m_n;

  // Wishbone monitor: pairs bus writes with AXI writes and derives B responses.
  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      aw_q.delete();
      w_q.delete();
      exp_b.delete();
      ready_at.delete();
      chk_after_err = 1'b0;
    end else begin
      if (chk_after_err) begin
        chk("cyc low after err", o_wb_cyc, 0);
        chk("stb low after err", o_wb_stb, 0);
        chk_after_err = 1'b0;
      end
      // A strobe is resolved this edge if accepted, or failed by a concurrent error.
      if (o_wb_stb && (!i_wb_stall || (o_wb_cyc && i_wb_err))) begin
        chk("wb write has axi source", (aw_q.size() != 0 && w_q.size() != 0), 1);
        if (aw_q.size() != 0 && w_q.size() != 0) begin
          m_a = aw_q.pop_front();
          m_w = w_q.pop_front();
          chk("wb addr", o_wb_addr, m_a);
          chk("wb data", o_wb_data, m_w[DW+SW-1:SW]);
          chk("wb sel", o_wb_sel, m_w[SW-1:0]);
          chk("wb we", o_wb_we, 1);
        end
        wb_acc++;
      end
      if (o_wb_cyc && i_wb_err) begin
        m_n = ready_at.size() + (o_wb_stb ? 1 : 0);
        repeat (m_n) exp_b.push_back(2'b10);
        ready_at.delete();
        chk_after_err = 1'b1;
      end else begin
        if (o_wb_cyc && i_wb_ack) begin
          if (ready_at.size() != 0) void'(ready_at.pop_front());
          exp_b.push_back(2'b00);
        end
        if (o_wb_stb && !i_wb_stall)
          ready_at.push_back(cyc_n + int'($urandom_range(ack_max, ack_min)));
      end
    end
  end

  // B channel monitor
  always @(negedge clk) begin
    if (!rst && o_axi_bvalid && i_axi_bready) begin
      chk("b response expected", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) chk("bresp", o_axi_bresp, exp_b.pop_front());
    end
  end

  // Wishbone slave responses, stall and bready drivers.
  always @(posedge clk) begin
    #1;
    i_wb_ack     = 1'b0;
    i_wb_err     = 1'b0;
    i_wb_stall   = (int'($urandom_range(99, 0)) < stall_pct);
    i_axi_bready = (int'($urandom_range(99, 0)) < bready_pct);
    if (!rst && ready_at.size() != 0 && ready_at[0] <= cyc_n) begin
      resp_idx++;
      if (resp_idx == err_at_resp || int'($urandom_range(99, 0)) < err_pct) i_wb_err = 1'b1;
      else i_wb_ack = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [AW-1:0] a);
    i_axi_awvalid = 1'b1;
    i_axi_awaddr  = a;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (o_axi_awready) begin
        aw_q.push_back(a);
        tick(1);
        i_axi_awvalid = 1'b0;
        return;
      end
      tick(1);
    end
    chk("aw handshake within bound", o_axi_awready, 1);
    i_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
    i_axi_wvalid = 1'b1;
    i_axi_wdata  = d;
    i_axi_wstrb  = s;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (o_axi_wready) begin
        w_q.push_back({d, s});
        tick(1);
        i_axi_wvalid = 1'b0;
        return;
      end
      tick(1);
    end
    chk("w handshake within bound", o_axi_wready, 1);
    i_axi_wvalid = 1'b0;
  endtask

  task automatic send_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (t < 2000 && !(aw_q.size() == 0 && w_q.size() == 0 && exp_b.size() == 0 &&
                         ready_at.size() == 0 && !o_wb_stb && !o_axi_bvalid)) begin
      tick(1);
      t++;
    end
    chk({name, " drained"}, t < 2000, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t;
    rst = 1'b1;
    i_axi_awvalid = 1'b0; i_axi_awaddr = '0; i_axi_awprot = 3'b000;
    i_axi_wvalid = 1'b0; i_axi_wdata = '0; i_axi_wstrb = '0;
    i_axi_bready = 1'b1; i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset awready", o_axi_awready, 1);
    chk("reset wready", o_axi_wready, 1);
    chk("reset bvalid", o_axi_bvalid, 0);
    chk("reset bresp", o_axi_bresp, 0);
    chk("reset cyc", o_wb_cyc, 0);
    chk("reset stb", o_wb_stb, 0);
    tick(1);

    // Single write: stb one cycle after a joint AW/W handshake, for one cycle.
    send_wr(26'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("single stb latency", o_wb_stb, 1);
    chk("single addr", o_wb_addr, 26'h10);
    tick(1);
    @(negedge clk);
    chk("single stb width", o_wb_stb, 0);
    tick(1);
    drain("single");

    // W ahead of AW.
    send_w(32'h0BADF00D, 4'h5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no stb without aw", o_wb_stb, 0);
      tick(1);
    end
    send_aw(26'h20);
    @(negedge clk);
    chk("w-first stb", o_wb_stb, 1);
    chk("w-first sel", o_wb_sel, 4'h5);
    tick(1);
    drain("w-first");

    // Credit limit: eight outstanding, ninth held.
    bready_pct = 0; ack_min = 4; ack_max = 4;
    tick(1);
    base = wb_acc;
    for (int i = 0; i < 9; i++) send_wr(AW'(32'h100 + i), $urandom, SW'($urandom));
    tick(20);
    @(negedge clk);
    chk("credit issued count", wb_acc - base, 8);
    chk("credit awready held", o_axi_awready, 0);
    chk("credit wready held", o_axi_wready, 0);
    chk("credit bvalid", o_axi_bvalid, 1);
    tick(1);
    bready_pct = 100;
    drain("credit");

    // Stall on the first strobe.
    stall_pct = 100; ack_min = 1; ack_max = 2;
    tick(1);
    send_wr(26'h3A5, 32'h12345678, 4'h3);
    send_wr(26'h3A6, 32'h9ABCDEF0, 4'hC);
    @(negedge clk);
    chk("stall stb", o_wb_stb, 1);
    chk("stall awready", o_axi_awready, 0);
    chk("stall wready", o_axi_wready, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      @(negedge clk);
      chk("stall addr stable", o_wb_addr, 26'h3A5);
      chk("stall data stable", o_wb_data, 32'h12345678);
    end
    tick(1);
    stall_pct = 0;
    drain("stall");

    // Error on the second of three in-flight writes, then a clean write.
    ack_min = 3; ack_max = 3;
    err_at_resp = resp_idx + 2;
    for (int i = 0; i < 3; i++) send_wr(AW'(32'h400 + i), $urandom, 4'hF);
    drain("err");
    err_at_resp = 0;
    send_wr(26'h500, 32'hCAFEF00D, 4'hF);
    drain("post-err");

    // Reset with writes in flight and a response waiting.
    bready_pct = 0; ack_min = 1; ack_max = 1;
    send_wr(26'h600, 32'h1, 4'h1);
    t = 0;
    while (!o_axi_bvalid && t < 50) begin tick(1); t++; end
    chk("pre-reset bvalid", o_axi_bvalid, 1);
    ack_min = 30; ack_max = 30;
    send_wr(26'h601, 32'h2, 4'h2);
    send_wr(26'h602, 32'h3, 4'h4);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset cyc", o_wb_cyc, 0);
    chk("post-reset stb", o_wb_stb, 0);
    chk("post-reset bvalid", o_axi_bvalid, 0);
    chk("post-reset awready", o_axi_awready, 1);
    chk("post-reset wready", o_axi_wready, 1);
    tick(1);
    bready_pct = 100; ack_min = 1; ack_max = 3;
    send_wr(26'h700, 32'h55AA55AA, 4'hF);
    drain("post-reset");

    // Randomized traffic with independent AW/W streams.
    stall_pct = 30; bready_pct = 70; err_pct = 4; ack_min = 1; ack_max = 5;
    fork
      for (int i = 0; i < 40; i++) begin
        tick(int'($urandom_range(2, 0)));
        send_aw(AW'($urandom));
      end
      for (int j = 0; j < 40; j++) begin
        tick(int'($urandom_range(2, 0)));
        send_w($urandom, SW'($urandom));
      end
    join
    stall_pct = 0; bready_pct = 100; err_pct = 0;
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axilwr2wbsp.md
Name: axilwr2wbsp

Overview:
- Companion to the AXI-lite read-to-Wishbone bridge; handles the AXI-lite write channel triple (AW, W, B).
- Joins one AW beat with one W beat and issues a single pipelined Wishbone write (we=1).
- Returns one B response per write, in order.
- Sits beside the read bridge in the AXI-lite slave front end; a Wishbone arbiter downstream merges both bridges.

Parameters:
- C_AXI_DATA_WIDTH, 32, AXI/WB data width; DW = C_AXI_DATA_WIDTH.
- C_AXI_ADDR_WIDTH, 28, AXI byte-address width; AW = C_AXI_ADDR_WIDTH - $clog2(DW/8) (word address, local).
- LGFIFO, 3, log2 of max outstanding writes and B-FIFO depth; FLEN = 2^LGFIFO.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_axi_awvalid  in  1  write address valid
- o_axi_awready  out  1  write address ready
- i_axi_awaddr  in  AW  word address
- i_axi_awprot  in  3  ignored
- i_axi_wvalid  in  1  write data valid
- o_axi_wready  out  1  write data ready
- i_axi_wdata  in  DW  write data
- i_axi_wstrb  in  DW/8  byte strobes
- o_axi_bvalid  out  1  response valid
- i_axi_bready  in  1  response ready
- o_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  strobe
- o_wb_we  out  1  tied 1
- o_wb_addr  out  AW  word address
- o_wb_data  out  DW  write data
- o_wb_sel  out  DW/8  copy of wstrb
- i_wb_stall  in  1  slave stall
- i_wb_ack  in  1  acknowledge
- i_wb_err  in  1  bus error

Behaviour:
- Reset values: awready=1, wready=1, bvalid=0, bresp=00, cyc=0, stb=0. addr/data/sel hold (no reset required). While i_reset is high, all in-flight state and queued responses are discarded.
- Input holding:
  - AW and W each have a one-entry holding register.
  - awready = !aw_held; wready = !w_held. Channels are accepted independently, so AW may arrive before W or W before AW.
- Issue condition, all must be true:
  - aw_held (or AW handshaking this cycle) and w_held (or W handshaking this cycle);
  - (!stb || !stall);
  - !flush;
  - inflight + bfifo_count + 1 <= FLEN.
- Issue action: stb<=1, cyc<=1, and addr/data/sel are loaded; both holding registers are consumed.
- Latency: with AW and W handshaking in the same cycle at idle, stb rises in the next cycle. Back-to-back issue is allowed at one write per cycle while stall is low.
- stb deasserts when (stb && !stall) and no new issue occurs.
- inflight counter (LGFIFO+1 bits):
  - +1 on stb&&!stall; -1 on ack; unchanged when both occur.
  - cyc drops the cycle after inflight reaches 0 with stb low.
- Ack handling: each ack pushes OKAY (0) into the B FIFO. Because of the credit rule the FIFO never overflows, and Wishbone is never back-pressured on acks.
- Error handling:
  - On cyc&&err, cyc and stb drop next cycle. The erroring write pushes SLVERR.
  - flush_cnt is loaded with the writes still owed: (inflight-1), plus 1 if stb is pending and not accepted.
  - While flush_cnt>0: push one SLVERR per cycle, decrement, issue nothing; AW/W holding registers may still fill.
  - Acks and errs are ignored while cyc=0.
- B channel:
  - bvalid = !fifo_empty; bresp = fifo head ? 2'b10 : 2'b00.
  - A pop happens on bvalid&&bready.
  - Push and pop in the same cycle are legal with the FIFO full or empty. The empty-FIFO push appears the next cycle (ack at cycle N gives bvalid at N+1).
- Simultaneous events:
  - An issue may coincide with an ack.
  - An err during an issue attempt cancels that issue; the holding registers stay unconsumed and issue again after the flush.
  - An err together with stb&&!stall counts the new write as inflight before the flush count is computed.

Decomposition:
- Shared package axil_wb_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - an AXI_LSBS helper function.
  The read bridge is migrated to the same package.
- One sub-module, axilwr_bfifo: synchronous 1-bit-wide FIFO, depth FLEN, with count output, push/pop, and full/empty flags.

Test Plan:
- Single write: AW=0x10 and W=0xDEADBEEF with wstrb=0xF in cycle 0, WB acks on first stb → stb for exactly one cycle, addr=0x10, data=0xDEADBEEF, sel=0xF; bvalid one cycle after ack, bresp=00.
- W three cycles before AW=0x20 → no stb until AW arrives; stb the cycle after AW handshake, sel equals the earlier wstrb.
- 8 back-to-back writes, stall=0, acks delayed 4 cycles, bready=0 → the 9th write is held (awready=0 after its AW is held); raising bready pops 8 OKAYs and the 9th write issues.
- Stall held 5 cycles on the first stb → addr/data stable throughout, a second write is held in the holding registers, awready=0 until issue.
- 3 writes in flight, err on the 2nd response (after 1 ack) → cyc drops next cycle; B sequence OKAY, SLVERR, SLVERR; then a new write completes OKAY.
- i_reset asserted with 2 in flight and bvalid=1 → next cycle cyc=0, stb=0, bvalid=0, awready=wready=1; a later write completes normally.
